// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared Gray/binary pointer conversion for the async FIFO
package fifo_pkg;

  // Functions work at a fixed maximum width; callers zero-extend and truncate.
  // Leading zeros are neutral in both conversions, so any width up to MAX_W is exact.
  localparam int MAX_W = 32;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b = g;
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rptr_empty.sv
// rtl/fifo_rptr_empty.sv - async FIFO read pointer, empty/almost-empty, level and underflow
module fifo_rptr_empty
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int AE_THRESH  = 2
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  rinc,
  input  logic                  rerr_clr,
  input  logic [ADDR_WIDTH:0]   wptr_gray_sync,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic                  rempty,
  output logic                  ralmost_empty,
  output logic [ADDR_WIDTH:0]   rlevel,
  output logic                  runderflow
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] AE_T = PTR_W'(AE_THRESH);

  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] rbin_next;
  logic [PTR_W-1:0] rgray_next;
  logic [PTR_W-1:0] wbin_sync;
  logic [PTR_W-1:0] level_next;
  logic             rd_ok;

  always_comb begin
    rd_ok      = rinc & ~rempty;
    rbin_next  = rbin + PTR_W'(rd_ok);
    rgray_next = PTR_W'(bin2gray(MAX_W'(rbin_next)));
    wbin_sync  = PTR_W'(gray2bin(MAX_W'(wptr_gray_sync)));
    // Modular difference; the stale write pointer can only make this low.
    level_next = wbin_sync - rbin_next;
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin          <= '0;
      rptr_gray     <= '0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      rlevel        <= '0;
      runderflow    <= 1'b0;
    end else begin
      rbin          <= rbin_next;
      rptr_gray     <= rgray_next;
      // Full-width compare: equal low bits with differing MSB is full, not empty.
      rempty        <= (rgray_next == wptr_gray_sync);
      ralmost_empty <= (level_next <= AE_T);
      rlevel        <= level_next;
      runderflow    <= (rinc & rempty) | (runderflow & ~rerr_clr);
    end
  end

  assign raddr = rbin[ADDR_WIDTH-1:0];

endmodule
